byte_mem_responder: RTL and testbench

- Responder end of the core's byte-wide memory bus. The memory-stage and instruction-fetch initiators drive address, write-enable and write byte; this block answers them.
- Contains a synchronous byte RAM with 1-cycle read latency and a small memory-mapped I/O window.
- The I/O window holds a TX byte FIFO drained by a valid/ready host port, plus a status register.
- Sits at top level between the CPU bus pins and the simulation/FPGA environment.

---
 rtl/byte_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_byte_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_responder.sv
// ---------------------------------------------------------------------------
// byte_mem_responder
//
// Responder end of the CPU's byte-wide memory bus. Every rising edge the
// initiator presents an address and a read/write flag, and this block either
// updates a synchronous byte RAM or touches a small I/O window. The I/O window
// holds a TX byte FIFO that a host drains over a valid/ready port, plus a
// status register showing the FIFO occupancy and a sticky overflow flag.
//
// I/O window (mem_a_i[31:4] == IO_BASE[31:4]):
//   IO_BASE+0  TXDATA  write pushes a byte (dropped and flagged when full),
//                      read returns 8'h00
//   IO_BASE+4  STATUS  read {overflow, zero pad, count}; write with bit 7 set
//                      clears overflow
//   IO_BASE+8  HALT    only with RESP_HALT_EN; otherwise unmapped like every
//                      other window offset (reads 8'h00, writes ignored)
// Any address outside the window reaches RAM through its low RAM_AW bits.
//
// Optional feature macro: RESP_HALT_EN
//   Adds the halt_o output, set by any write to IO_BASE+8 and held until rst.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   mem_a_i     in   [31:0] byte address from the initiator
//   mem_wr_i    in   1 = write mem_din_i at mem_a_i, 0 = read
//   mem_din_i   in   [7:0] write byte
//   mem_dout_o  out  [7:0] registered read byte (1-cycle read latency)
//   tx_valid_o  out  FIFO head byte available to the host
//   tx_data_o   out  [7:0] FIFO head byte
//   tx_ready_i  in   host accepts the head byte this cycle
//   io_full_o   out  TX FIFO full, used by the stall controller to hold stores
//   halt_o      out  (RESP_HALT_EN only) sticky halt request
// ---------------------------------------------------------------------------
module byte_mem_responder #(
    parameter int          RAM_AW  = 17,
    parameter logic [31:0] IO_BASE = 32'h0003_0000,
    parameter int          FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_din_i,
    output logic [7:0]  mem_dout_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        io_full_o
`ifdef RESP_HALT_EN
    ,
    output logic        halt_o
`endif
);

    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    // Storage: RAM and FIFO slots are never reset
    logic [7:0] ram      [0:(2**RAM_AW)-1];
    logic [7:0] fifo_mem [0:DEPTH-1];

    // FIFO bookkeeping
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr_nxt;
    logic [FIFO_AW-1:0] rd_ptr_nxt;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_nxt;
    logic               overflow;
    logic [7:0]         head_nxt;

    // Decode
    logic               in_io;
    logic [3:0]         io_off;
    logic [RAM_AW-1:0]  ram_idx;
    logic               sel_txdata;
    logic               sel_status;
    logic               fifo_full;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               overflow_set;
    logic               overflow_clr;
    logic [7:0]         io_rd_data;

    assign in_io      = (mem_a_i[31:4] == IO_BASE[31:4]);
    assign io_off     = mem_a_i[3:0];
    assign ram_idx    = mem_a_i[RAM_AW-1:0];
    assign sel_txdata = in_io && (io_off == 4'h0);
    assign sel_status = in_io && (io_off == 4'h4);

    // A pop is only possible while the registered valid is high, so a push
    // into an empty FIFO never bypasses straight to the host. When full, a
    // simultaneous pop frees the slot the push needs.
    assign fifo_full    = (count == CNT_FULL);
    assign pop          = tx_valid_o && tx_ready_i;
    assign push_req     = sel_txdata && mem_wr_i;
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = sel_status && mem_wr_i && mem_din_i[7];

`ifdef RESP_HALT_EN
    logic sel_halt;
    assign sel_halt = in_io && (io_off == 4'h8);
`endif

    // Next FIFO state. The new head is the byte being pushed whenever the
    // push lands exactly in the slot the read pointer will point at (empty
    // FIFO, or a single entry popped while a new one arrives); otherwise it
    // is the stored slot, which keeps tx_data_o stable while the host stalls.
    always_comb begin
        wr_ptr_nxt = push ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = mem_din_i;
        end else begin
            head_nxt = fifo_mem[rd_ptr_nxt];
        end
    end

    // Read data for the I/O window; unmapped offsets and TXDATA read as zero
    always_comb begin
        io_rd_data = 8'h00;
        if (sel_status) begin
            io_rd_data[FIFO_AW:0] = count;
            io_rd_data[7]         = overflow;
        end
`ifdef RESP_HALT_EN
        if (sel_halt) begin
            io_rd_data = {7'b0, halt_o};
        end
`endif
    end

    // RAM write port; the address aliases through its low RAM_AW bits
    always_ff @(posedge clk) begin
        if (mem_wr_i && !in_io) begin
            ram[ram_idx] <= mem_din_i;
        end
    end

    // Registered read data; write cycles leave the previous value in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dout_o <= 8'h00;
        end else if (!mem_wr_i) begin
            mem_dout_o <= in_io ? io_rd_data : ram[ram_idx];
        end
    end

    // FIFO slot write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_din_i;
        end
    end

    // FIFO pointers, occupancy, overflow flag and registered host outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
            io_full_o  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            tx_valid_o <= (count_nxt != '0);
            tx_data_o  <= head_nxt;
            io_full_o  <= (count_nxt == CNT_FULL);
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef RESP_HALT_EN
    // Sticky halt request, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_o <= 1'b0;
        end else if (sel_halt && mem_wr_i) begin
            halt_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_byte_mem_responder
//
// Directed bench for byte_mem_responder. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a period away from the
// rising edge where the DUT updates. Each scenario task performs its own
// comparisons against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_byte_mem_responder;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] TXDATA  = IO_BASE + 32'd0;
    localparam logic [31:0] STATUS  = IO_BASE + 32'd4;
    localparam logic [31:0] IDLE_A  = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a_i;
    logic        mem_wr_i;
    logic [7:0]  mem_din_i;
    logic [7:0]  mem_dout_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        io_full_o;
`ifdef RESP_HALT_EN
    logic        halt_o;
`endif

    int passed;
    int total;

    byte_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .mem_a_i    (mem_a_i),
        .mem_wr_i   (mem_wr_i),
        .mem_din_i  (mem_din_i),
        .mem_dout_o (mem_dout_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .io_full_o  (io_full_o)
`ifdef RESP_HALT_EN
        ,
        .halt_o     (halt_o)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: present the transaction, let one rising edge take it,
    // return on the following falling edge with outputs settled
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a_i   = a;
        mem_wr_i  = wr;
        mem_din_i = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(IDLE_A, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_ready_i = 1'b0;
        mem_a_i = IDLE_A;
        mem_wr_i = 1'b0;
        mem_din_i = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (mem_dout_o !== 8'h00) $display("[TB] FAIL rst_dout: got %h want %h", mem_dout_o, 8'h00); else passed++;
        total++; if (tx_valid_o !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", tx_valid_o); else passed++;
        total++; if (tx_data_o !== 8'h00) $display("[TB] FAIL rst_data: got %h want %h", tx_data_o, 8'h00); else passed++;
        total++; if (io_full_o !== 1'b0) $display("[TB] FAIL rst_full: got %b want 0", io_full_o); else passed++;
        rst = 1'b0;
        cyc(IDLE_A, 1'b1, 8'h5A);
    endtask

    task automatic test_ram();
        cyc(IDLE_A, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h5A) $display("[TB] FAIL ram_idle_read: got %h want %h", mem_dout_o, 8'h5A); else passed++;
        cyc(32'h0000_0010, 1'b1, 8'hA5);
        total++; if (mem_dout_o !== 8'h5A) $display("[TB] FAIL ram_write_holds_dout: got %h want %h", mem_dout_o, 8'h5A); else passed++;
        cyc(32'h0000_0010, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'hA5) $display("[TB] FAIL ram_roundtrip: got %h want %h", mem_dout_o, 8'hA5); else passed++;
        cyc(32'h0000_0004, 1'b1, 8'h3C);
        cyc(32'h0002_0004, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h3C) $display("[TB] FAIL ram_alias_2pow: got %h want %h", mem_dout_o, 8'h3C); else passed++;
        cyc(32'hFFFE_0004, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h3C) $display("[TB] FAIL ram_alias_high: got %h want %h", mem_dout_o, 8'h3C); else passed++;
    endtask

    task automatic test_unmapped();
        // 0x3000C aliases RAM 0x1000C when decoded as RAM, so a decode slip shows
        cyc(32'h0001_000C, 1'b1, 8'h77);
        cyc(32'h0003_000C, 1'b1, 8'h11);
        cyc(32'h0001_000C, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h77) $display("[TB] FAIL unmapped_write_ignored: got %h want %h", mem_dout_o, 8'h77); else passed++;
        cyc(32'h0003_000C, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h00) $display("[TB] FAIL unmapped_read_zero: got %h want %h", mem_dout_o, 8'h00); else passed++;
        total++; if (tx_valid_o !== 1'b0) $display("[TB] FAIL unmapped_no_push: got %b want 0", tx_valid_o); else passed++;
    endtask

    task automatic test_fifo_fill();
        tx_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc(TXDATA, 1'b1, 8'(i));
            total++; if (tx_data_o !== 8'h01) $display("[TB] FAIL fill_head_%0d: got %h want %h", i, tx_data_o, 8'h01); else passed++;
        end
        total++; if (io_full_o !== 1'b1) $display("[TB] FAIL fill_full: got %b want 1", io_full_o); else passed++;
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h08) $display("[TB] FAIL fill_status: got %h want %h", mem_dout_o, 8'h08); else passed++;
        cyc(TXDATA, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h00) $display("[TB] FAIL txdata_read_zero: got %h want %h", mem_dout_o, 8'h00); else passed++;
        cyc(TXDATA, 1'b1, 8'h09);
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h88) $display("[TB] FAIL overflow_set: got %h want %h", mem_dout_o, 8'h88); else passed++;
        cyc(STATUS, 1'b1, 8'h7F);
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h88) $display("[TB] FAIL overflow_kept_bit7_clear: got %h want %h", mem_dout_o, 8'h88); else passed++;
        cyc(STATUS, 1'b1, 8'h80);
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h08) $display("[TB] FAIL overflow_cleared: got %h want %h", mem_dout_o, 8'h08); else passed++;
    endtask

    task automatic test_drain();
        tx_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(i)) $display("[TB] FAIL drain_%0d: got valid %b data %h want valid 1 data %h", i, tx_valid_o, tx_data_o, 8'(i)); else passed++;
            idle();
        end
        total++; if (tx_valid_o !== 1'b0) $display("[TB] FAIL drain_empty: got %b want 0", tx_valid_o); else passed++;
        total++; if (io_full_o !== 1'b0) $display("[TB] FAIL drain_not_full: got %b want 0", io_full_o); else passed++;
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h00) $display("[TB] FAIL drain_status: got %h want %h", mem_dout_o, 8'h00); else passed++;
        // Push into an empty FIFO while ready is high: no bypass, byte appears
        cyc(TXDATA, 1'b1, 8'h55);
        total++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h55) $display("[TB] FAIL empty_push_pop: got valid %b data %h want valid 1 data 55", tx_valid_o, tx_data_o); else passed++;
        idle();
        total++; if (tx_valid_o !== 1'b0) $display("[TB] FAIL empty_push_pop_drained: got %b want 0", tx_valid_o); else passed++;
        tx_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] expect_seq [0:7];
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) cyc(TXDATA, 1'b1, 8'h11 + 8'(i));
        tx_ready_i = 1'b1;
        cyc(TXDATA, 1'b1, 8'h0A);
        tx_ready_i = 1'b0;
        total++; if (io_full_o !== 1'b1) $display("[TB] FAIL pushpop_full: got %b want 1", io_full_o); else passed++;
        total++; if (tx_data_o !== 8'h12) $display("[TB] FAIL pushpop_head: got %h want %h", tx_data_o, 8'h12); else passed++;
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h08) $display("[TB] FAIL pushpop_status: got %h want %h", mem_dout_o, 8'h08); else passed++;
        for (int i = 0; i < 7; i++) expect_seq[i] = 8'h12 + 8'(i);
        expect_seq[7] = 8'h0A;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tx_valid_o !== 1'b1 || tx_data_o !== expect_seq[i]) $display("[TB] FAIL pushpop_drain_%0d: got valid %b data %h want valid 1 data %h", i, tx_valid_o, tx_data_o, expect_seq[i]); else passed++;
            idle();
        end
        total++; if (tx_valid_o !== 1'b0) $display("[TB] FAIL pushpop_empty: got %b want 0", tx_valid_o); else passed++;
        tx_ready_i = 1'b0;
    endtask

`ifdef RESP_HALT_EN
    task automatic test_halt();
        total++; if (halt_o !== 1'b0) $display("[TB] FAIL halt_initial: got %b want 0", halt_o); else passed++;
        cyc(IO_BASE + 32'd8, 1'b1, 8'h00);
        total++; if (halt_o !== 1'b1) $display("[TB] FAIL halt_set: got %b want 1", halt_o); else passed++;
        repeat (3) idle();
        cyc(IO_BASE + 32'd8, 1'b0, 8'h00);
        total++; if (halt_o !== 1'b1 || mem_dout_o !== 8'h01) $display("[TB] FAIL halt_sticky_read: got halt %b dout %h want halt 1 dout 01", halt_o, mem_dout_o); else passed++;
    endtask
`endif

    task automatic test_async_reset();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc(TXDATA, 1'b1, 8'hC0 + 8'(i));
        total++; if (tx_valid_o !== 1'b1) $display("[TB] FAIL areset_pre_valid: got %b want 1", tx_valid_o); else passed++;
        tx_ready_i = 1'b1;
        idle();
        #2 rst = 1'b1;
        #1;
        total++; if (tx_valid_o !== 1'b0 || io_full_o !== 1'b0 || tx_data_o !== 8'h00) $display("[TB] FAIL areset_immediate: got valid %b full %b data %h want 0 0 00", tx_valid_o, io_full_o, tx_data_o); else passed++;
`ifdef RESP_HALT_EN
        total++; if (halt_o !== 1'b0) $display("[TB] FAIL areset_halt: got %b want 0", halt_o); else passed++;
`endif
        @(negedge clk);
        rst = 1'b0;
        tx_ready_i = 1'b0;
        cyc(STATUS, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'h00) $display("[TB] FAIL areset_status: got %h want %h", mem_dout_o, 8'h00); else passed++;
        cyc(32'h0000_0010, 1'b0, 8'h00);
        total++; if (mem_dout_o !== 8'hA5) $display("[TB] FAIL areset_ram_kept: got %h want %h", mem_dout_o, 8'hA5); else passed++;
        // Full FIFO: io_full_o must drop as soon as reset asserts
        for (int i = 0; i < 8; i++) cyc(TXDATA, 1'b1, 8'(i));
        idle();
        #2 rst = 1'b1;
        #1;
        total++; if (io_full_o !== 1'b0 || tx_valid_o !== 1'b0) $display("[TB] FAIL areset_full_drop: got full %b valid %b want 0 0", io_full_o, tx_valid_o); else passed++;
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_ram();
        test_unmapped();
        test_fifo_fill();
        test_drain();
        test_back_to_back();
`ifdef RESP_HALT_EN
        test_halt();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
